// File: rtl/miniled_pkg.sv
// Shared definitions for the MiniLED serial link (driver and capture side).
//   CH_NUM, DW, FRAME_BITS : frame geometry
//   SCAN_N                 : number of scan lines
//   state_t                : link FSM states
//   scan_decode()          : active-low one-hot scan decode
package miniled_pkg;

    localparam int CH_NUM     = 9;
    localparam int DW         = 8;
    localparam int FRAME_BITS = CH_NUM * DW;
    localparam int SCAN_N     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Returns {valid, index}; valid only when exactly one scan line is low.
    function automatic logic [2:0] scan_decode(input logic [SCAN_N-1:0] s);
        logic [1:0] idx;
        int         n;
        idx = '0;
        n   = 0;
        for (int i = 0; i < SCAN_N; i++) begin
            if (!s[i]) begin
                n   = n + 1;
                idx = 2'(i);
            end
        end
        return {(n == 1), idx};
    endfunction

endpackage

// File: rtl/miniled_sdi_capture_if.sv
// Pin-side and result-side signals of the SDI capture block.
//   master : drives the driver pins (I_*), observes results (O_*)
//   slave  : the capture block itself
interface miniled_sdi_capture_if
    import miniled_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int GCNT_W = 16
);
    logic                  I_dclk;
    logic                  I_sdi;
    logic                  I_le;
    logic                  I_gclk;
    logic [SCAN_N-1:0]     I_scan;
    logic [FRAME_BITS-1:0] O_data;
    logic [1:0]            O_row;
    logic                  O_frame_vld;
    logic                  O_len_err;
    logic                  O_scan_err;
    logic [CNT_W-1:0]      O_bit_cnt;
    logic [GCNT_W-1:0]     O_gclk_cnt;

    modport master (
        output I_dclk, I_sdi, I_le, I_gclk, I_scan,
        input  O_data, O_row, O_frame_vld, O_len_err, O_scan_err, O_bit_cnt, O_gclk_cnt
    );

    modport slave (
        input  I_dclk, I_sdi, I_le, I_gclk, I_scan,
        output O_data, O_row, O_frame_vld, O_len_err, O_scan_err, O_bit_cnt, O_gclk_cnt
    );
endinterface

// File: rtl/miniled_sdi_capture_edge_sync.sv
// 2-flop synchronizer with rising-edge detect.
//   i_sig  : asynchronous signals needing edge detection
//   i_aux  : asynchronous level-only signals, carried at the same depth
//   o_rise : one-cycle pulse per synchronized rising edge of i_sig
//   o_aux  : synchronized i_aux, aligned with the cycle o_rise fires
module edge_sync #(
    parameter int W     = 1,
    parameter int AUX_W = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [W-1:0]     i_sig,
    input  logic [AUX_W-1:0] i_aux,
    output logic [W-1:0]     o_rise,
    output logic [AUX_W-1:0] o_aux
);
    logic [W-1:0]     r_s1, r_s2, r_dly;
    logic [AUX_W-1:0] r_a1, r_a2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_dly <= '0;
            r_a1  <= '0;
            r_a2  <= '0;
        end else begin
            r_s1  <= i_sig;
            r_s2  <= r_s1;
            r_dly <= r_s2;
            r_a1  <= i_aux;
            r_a2  <= r_a1;
        end
    end

    assign o_rise = r_s2 & ~r_dly;
    assign o_aux  = r_a2;
endmodule

// File: rtl/miniled_sdi_capture.sv
// Receiving front end of the MiniLED serial link: oversamples the driver
// pins, shifts SDI on DCLK rises and latches the frame on LE rises.
//   I_clk, I_rst : 50 MHz system clock, async active-high reset
//   bus          : pins in (dclk, sdi, le, gclk, scan), latched results out
module miniled_sdi_capture
    import miniled_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int GCNT_W = 16
) (
    input  logic                   I_clk,
    input  logic                   I_rst,
    miniled_sdi_capture_if.slave   bus
);
    logic [2:0]        w_rise;
    logic [SCAN_N:0]   w_aux;
    logic              w_dclk_rise, w_le_rise, w_gclk_rise;
    logic              w_sdi;
    logic [SCAN_N-1:0] w_scan;
    logic [2:0]        w_scan_dec;

    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [GCNT_W-1:0]     r_gclk_cnt;
    logic [FRAME_BITS-1:0] r_data;
    logic [1:0]            r_row;
    logic                  r_frame_vld, r_len_err, r_scan_err;
    logic [CNT_W-1:0]      r_bit_cnt_out;
    logic [GCNT_W-1:0]     r_gclk_out;

    // sdi and scan ride alongside the edge-detected pins so the sampled
    // data bit lines up with the detected DCLK rise.
    edge_sync #(.W(3), .AUX_W(SCAN_N + 1)) u_sync (
        .i_clk  (I_clk),
        .i_rst  (I_rst),
        .i_sig  ({bus.I_gclk, bus.I_le, bus.I_dclk}),
        .i_aux  ({bus.I_scan, bus.I_sdi}),
        .o_rise (w_rise),
        .o_aux  (w_aux)
    );

    assign w_dclk_rise = w_rise[0];
    assign w_le_rise   = w_rise[1];
    assign w_gclk_rise = w_rise[2];
    assign w_sdi       = w_aux[0];
    assign w_scan      = w_aux[SCAN_N:1];
    assign w_scan_dec  = scan_decode(w_scan);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state       <= IDLE;
            r_shreg       <= '0;
            r_bit_cnt     <= '0;
            r_gclk_cnt    <= '0;
            r_data        <= '0;
            r_row         <= '0;
            r_frame_vld   <= 1'b0;
            r_len_err     <= 1'b0;
            r_scan_err    <= 1'b0;
            r_bit_cnt_out <= '0;
            r_gclk_out    <= '0;
        end else begin
            r_frame_vld <= 1'b0;
            r_len_err   <= 1'b0;
            r_scan_err  <= 1'b0;

            // A GCLK rise during LATCH belongs to the interval just starting.
            if (r_state == LATCH) begin
                r_gclk_out <= r_gclk_cnt;
                r_gclk_cnt <= w_gclk_rise ? GCNT_W'(1) : '0;
            end else if (w_gclk_rise && r_gclk_cnt != '1) begin
                r_gclk_cnt <= r_gclk_cnt + 1'b1;
            end

            if (r_state == LATCH) begin
                r_bit_cnt_out <= r_bit_cnt;
                if (r_bit_cnt == CNT_W'(FRAME_BITS)) begin
                    r_data      <= r_shreg;
                    r_frame_vld <= 1'b1;
                end else begin
                    r_len_err   <= 1'b1;
                end
                if (w_scan_dec[2])
                    r_row <= w_scan_dec[1:0];
                else
                    r_scan_err <= 1'b1;

                // A DCLK rise here starts the next frame rather than being lost.
                if (w_dclk_rise) begin
                    r_shreg   <= {{(FRAME_BITS-1){1'b0}}, w_sdi};
                    r_bit_cnt <= CNT_W'(1);
                    r_state   <= SHIFT;
                end else begin
                    r_shreg   <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= IDLE;
                end
            end else begin
                // Shift in the same cycle as an LE rise so LATCH sees the bit.
                if (w_dclk_rise) begin
                    r_shreg <= {r_shreg[FRAME_BITS-2:0], w_sdi};
                    if (r_bit_cnt != '1)
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_le_rise) begin
                    r_state <= LATCH;
                end else if (w_dclk_rise) begin
                    if (r_bit_cnt >= CNT_W'(FRAME_BITS))
                        r_state <= OVER;
                    else if (r_state == IDLE)
                        r_state <= SHIFT;
                end
            end
        end
    end

    assign bus.O_data      = r_data;
    assign bus.O_row       = r_row;
    assign bus.O_frame_vld = r_frame_vld;
    assign bus.O_len_err   = r_len_err;
    assign bus.O_scan_err  = r_scan_err;
    assign bus.O_bit_cnt   = r_bit_cnt_out;
    assign bus.O_gclk_cnt  = r_gclk_out;
endmodule

// File: tb/tb_miniled_sdi_capture.sv
// Randomized + directed bench for miniled_sdi_capture with a frame-level
// reference model (expected latch results computed from the bits sent).
module tb_miniled_sdi_capture;
    import miniled_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    // reference state
    logic [FRAME_BITS-1:0] m_data;
    logic [1:0]            m_row;
    int                    m_gclk;

    miniled_sdi_capture_if #(.CNT_W(8), .GCNT_W(16)) bus ();

    miniled_sdi_capture #(.CNT_W(8), .GCNT_W(16)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pins_idle();
        bus.I_dclk = 1'b0;
        bus.I_sdi  = 1'b0;
        bus.I_le   = 1'b0;
        bus.I_gclk = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        bus.I_dclk = 1'b0;
        bus.I_sdi  = b;
        repeat (2) @(negedge clk);
        bus.I_dclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic gclk_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.I_gclk = 1'b1;
            repeat (2) @(negedge clk);
            bus.I_gclk = 1'b0;
            repeat (2) @(negedge clk);
        end
        m_gclk = (m_gclk + n > 65535) ? 65535 : m_gclk + n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pins_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        m_data = '0;
        m_row  = '0;
        m_gclk = 0;
        chk("rst_data", 128'(bus.O_data), 128'(0));
        chk("rst_row", 128'(bus.O_row), 128'(0));
        chk("rst_bitcnt", 128'(bus.O_bit_cnt), 128'(0));
        chk("rst_gclk", 128'(bus.O_gclk_cnt), 128'(0));
    endtask

    // Send n bits (first n of v MSB-first, random filler beyond 72), latch,
    // then compare every latch result with the model.
    task automatic do_frame(input logic [FRAME_BITS-1:0] v, input int n,
                            input logic [3:0] scan, input bit coinc, input int gp);
        int   vld_c, len_c, scn_c, zeros, zidx, exp_b;
        logic b;
        bus.I_scan = scan;
        gclk_pulses(gp);
        for (int i = 0; i < n; i++) begin
            b = (i < FRAME_BITS) ? v[FRAME_BITS-1-i] : 1'($urandom);
            if (coinc && i == n - 1) begin
                bus.I_dclk = 1'b0;
                bus.I_sdi  = b;
                repeat (2) @(negedge clk);
                bus.I_dclk = 1'b1;
                bus.I_le   = 1'b1;
            end else begin
                send_bit(b);
            end
        end
        bus.I_le = 1'b1;
        vld_c = 0; len_c = 0; scn_c = 0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (w == 2) bus.I_le = 1'b0;
            vld_c += int'(bus.O_frame_vld);
            len_c += int'(bus.O_len_err);
            scn_c += int'(bus.O_scan_err);
        end
        zeros = 0; zidx = 0;
        for (int i = 0; i < 4; i++)
            if (!scan[i]) begin zeros++; zidx = i; end
        exp_b = (n > 255) ? 255 : n;
        if (n == FRAME_BITS) m_data = v;
        if (zeros == 1) m_row = 2'(zidx);
        chk("frame_vld", 128'(vld_c), 128'((n == FRAME_BITS) ? 1 : 0));
        chk("len_err", 128'(len_c), 128'((n != FRAME_BITS) ? 1 : 0));
        chk("scan_err", 128'(scn_c), 128'((zeros != 1) ? 1 : 0));
        chk("bit_cnt", 128'(bus.O_bit_cnt), 128'(exp_b));
        chk("data", 128'(bus.O_data), 128'(m_data));
        chk("row", 128'(bus.O_row), 128'(m_row));
        chk("gclk_cnt", 128'(bus.O_gclk_cnt), 128'(m_gclk));
        m_gclk = 0;
    endtask

    initial begin
        logic [FRAME_BITS-1:0] pat, rv;
        logic [3:0]            sc;
        int                    sel, n;
        bit                    co;

        for (int k = 0; k < CH_NUM; k++) pat[k*DW +: DW] = 8'(k + 1);

        // reset with random pin activity
        bus.I_scan = 4'hF;
        pins_idle();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.I_dclk = 1'($urandom); bus.I_sdi = 1'($urandom);
            bus.I_le   = 1'($urandom); bus.I_gclk = 1'($urandom);
            bus.I_scan = 4'($urandom);
        end
        chk("rst_vld", 128'(bus.O_frame_vld), 128'(0));
        chk("rst_len", 128'(bus.O_len_err), 128'(0));
        chk("rst_scan", 128'(bus.O_scan_err), 128'(0));
        do_reset();

        // good frame, scan1 low... scan[1] low -> row 1
        do_frame(pat, 72, 4'b1101, 1'b0, 5);
        chk("ch0", 128'(bus.O_data[7:0]), 128'(8'h01));
        chk("ch8", 128'(bus.O_data[71:64]), 128'(8'h09));
        // short, long, bad scan
        do_frame(~pat, 70, 4'b1101, 1'b0, 0);
        do_frame(~pat, 300, 4'b1101, 1'b0, 3);
        do_frame(~pat, 72, 4'b1100, 1'b0, 0);
        // 513 GCLK rises with DCLK coincident with LE
        do_frame(pat ^ 72'h5A, 72, 4'b1011, 1'b1, 513);
        // reset mid-frame at bit 40, then a clean frame
        for (int i = 0; i < 40; i++) send_bit(1'($urandom));
        do_reset();
        do_frame(pat, 72, 4'b0111, 1'b0, 2);
        // latch with no bits
        do_frame(pat, 0, 4'b1110, 1'b0, 1);

        for (int t = 0; t < 20; t++) begin
            rv  = FRAME_BITS'({$urandom, $urandom, $urandom});
            sel = $urandom_range(0, 9);
            case (sel)
                6:       n = $urandom_range(0, 71);
                7:       n = $urandom_range(73, 100);
                8:       n = $urandom_range(255, 300);
                default: n = 72;
            endcase
            case ($urandom_range(0, 4))
                0: sc = 4'b1110;
                1: sc = 4'b1101;
                2: sc = 4'b1011;
                3: sc = 4'b0111;
                default: sc = 4'($urandom);
            endcase
            if (sel == 9) sc = 4'b0011;
            co = (n > 0) && ($urandom_range(0, 1) == 1);
            do_frame(rv, n, sc, co, $urandom_range(0, 15));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
